// File: rtl/pwm_pkg.sv
// Shared types for the breathing PWM generator.
package pwm_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_duty_seq.sv
// Triangle duty sequencer: steps duty up to PERIOD and back down to 0,
// holding each value for HOLD_PERIODS period-wrap strobes.
module pwm_duty_seq
    import pwm_pkg::*;
#(
    parameter int unsigned PERIOD       = 10,
    parameter int unsigned DUTY_STEP    = 1,
    parameter int unsigned HOLD_PERIODS = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wrap,
    output logic [$clog2(PERIOD+1)-1:0]  duty
);

    localparam int unsigned DW = $clog2(PERIOD + 1);
    localparam int unsigned SW = DW + 1;
    localparam int unsigned HW = $clog2(HOLD_PERIODS + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_PERIODS - 1);
    localparam logic [SW-1:0] STEP_W    = SW'(DUTY_STEP);
    localparam logic [SW-1:0] PERIOD_W  = SW'(PERIOD);
    localparam logic [DW-1:0] STEP_D    = DW'(DUTY_STEP);
    localparam logic [DW-1:0] PERIOD_D  = DW'(PERIOD);

    dir_e          dir, dir_nxt;
    logic [HW-1:0] hold, hold_nxt;
    logic [DW-1:0] duty_nxt;
    logic [SW-1:0] sum;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty <= '0;
            dir  <= DIR_UP;
            hold <= '0;
        end else begin
            duty <= duty_nxt;
            dir  <= dir_nxt;
            hold <= hold_nxt;
        end
    end

    // Next duty/direction/hold; sum carries an extra bit so it cannot wrap
    always_comb begin
        duty_nxt = duty;
        dir_nxt  = dir;
        hold_nxt = hold;
        sum      = {1'b0, duty} + STEP_W;
        if (wrap) begin
            if (hold != HOLD_LAST) begin
                hold_nxt = hold + HW'(1);
            end else begin
                hold_nxt = '0;
                if (dir == DIR_UP) begin
                    if (sum >= PERIOD_W) begin
                        duty_nxt = PERIOD_D;
                        dir_nxt  = DIR_DOWN;
                    end else begin
                        duty_nxt = sum[DW-1:0];
                    end
                end else begin
                    if (duty <= STEP_D) begin
                        duty_nxt = '0;
                        dir_nxt  = DIR_UP;
                    end else begin
                        duty_nxt = duty - STEP_D;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pwm.sv
// Self-running breathing PWM: free-running period counter compared against
// a triangle-swept duty value, output taken straight from a flop.
module pwm #(
    parameter int unsigned PERIOD       = 10,
    parameter int unsigned DUTY_STEP    = 1,
    parameter int unsigned HOLD_PERIODS = 1
) (
    input  logic clk,
    input  logic rst,
    output logic dout
);

    localparam int unsigned CW = $clog2(PERIOD);
    localparam int unsigned DW = $clog2(PERIOD + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;
    logic [DW-1:0] duty;
    logic          wrap_c;

    assign wrap_c = (cnt == CNT_LAST);

    pwm_duty_seq #(
        .PERIOD       (PERIOD),
        .DUTY_STEP    (DUTY_STEP),
        .HOLD_PERIODS (HOLD_PERIODS)
    ) u_duty_seq (
        .clk  (clk),
        .rst  (rst),
        .wrap (wrap_c),
        .duty (duty)
    );

    // Counter and compare; dout lags cnt by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            cnt  <= wrap_c ? '0 : cnt + CW'(1);
            dout <= (DW'(cnt) < duty);
        end
    end

endmodule

// File: tb/tb_pwm.sv
// Scoreboard bench for pwm: three configurations run side by side, expected
// dout bits queued per period from duty tables and popped every cycle.
module tb_pwm;

    logic clk;
    logic rst;
    logic dout_a, dout_b, dout_c;

    int n_cmp;
    int n_err;
    int cyc;
    bit q_a[$];
    bit q_b[$];
    bit q_c[$];

    pwm #(.PERIOD(10), .DUTY_STEP(1), .HOLD_PERIODS(1)) u_a (.clk(clk), .rst(rst), .dout(dout_a));
    pwm #(.PERIOD(8),  .DUTY_STEP(3), .HOLD_PERIODS(2)) u_b (.clk(clk), .rst(rst), .dout(dout_b));
    pwm #(.PERIOD(2),  .DUTY_STEP(2), .HOLD_PERIODS(1)) u_c (.clk(clk), .rst(rst), .dout(dout_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Triangle 0..10..0 with period 20
    function automatic int duty_a(input int k);
        int m;
        m = k % 20;
        return (m < 10) ? m : 20 - m;
    endfunction

    function automatic int duty_b(input int k);
        case (k % 12)
            0, 1:    return 0;
            2, 3:    return 3;
            4, 5:    return 6;
            6, 7:    return 8;
            8, 9:    return 5;
            default: return 2;
        endcase
    endfunction

    function automatic int duty_c(input int k);
        return (k % 2 == 0) ? 0 : 2;
    endfunction

    task automatic push_a(input int nper);
        for (int k = 0; k < nper; k++)
            for (int i = 0; i < 10; i++) q_a.push_back(i < duty_a(k));
    endtask

    task automatic push_b(input int nper);
        for (int k = 0; k < nper; k++)
            for (int i = 0; i < 8; i++) q_b.push_back(i < duty_b(k));
    endtask

    task automatic push_c(input int nper);
        for (int k = 0; k < nper; k++)
            for (int i = 0; i < 2; i++) q_c.push_back(i < duty_c(k));
    endtask

    // An empty queue yields X so the comparison is reported, not skipped
    function automatic logic pop_a();
        if (q_a.size() == 0) return 1'bx;
        return q_a.pop_front();
    endfunction

    function automatic logic pop_b();
        if (q_b.size() == 0) return 1'bx;
        return q_b.pop_front();
    endfunction

    function automatic logic pop_c();
        if (q_c.size() == 0) return 1'bx;
        return q_c.pop_front();
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            cyc++;
            check("seq_a", dout_a, pop_a());
            check("seq_b", dout_b, pop_b());
            check("seq_c", dout_c, pop_c());
        end
    endtask

    task automatic flush();
        q_a.delete();
        q_b.delete();
        q_c.delete();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;

        // Reset before any clock edge: outputs clear asynchronously
        rst = 1'b1;
        #2;
        check("rst_async_a", dout_a, 1'b0);
        check("rst_async_b", dout_b, 1'b0);
        check("rst_async_c", dout_c, 1'b0);
        #18;
        check("rst_hold_a", dout_a, 1'b0);
        check("rst_hold_b", dout_b, 1'b0);
        check("rst_hold_c", dout_c, 1'b0);

        // Full ramp up, both extremes, ramp down, and first period of the next ramp
        @(negedge clk);
        rst = 1'b0;
        push_a(23);
        push_b(28);
        push_c(111);
        step(220);
        flush();

        // Restart, then run into period 6 (duty 6) of the default instance
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_a(8);
        push_b(9);
        push_c(33);
        step(63);
        check("pre_rst_high_a", dout_a, 1'b1);

        // Reset between edges must clear dout without a clock edge
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_a", dout_a, 1'b0);
        check("mid_rst_b", dout_b, 1'b0);
        check("mid_rst_c", dout_c, 1'b0);
        flush();
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_hold_a", dout_a, 1'b0);
        rst = 1'b0;

        // Sequence restarts from duty 0, direction up
        push_a(5);
        push_b(7);
        push_c(25);
        step(50);
        flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
